// File: rtl/serial_add_pkg.sv
// Shared state encoding and sizing helpers
// for the bit-serial adder controller.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Bit count for a counter reaching w without wrap.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand-in and result-out handshakes
// of the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  out_ready,
    output in_ready, out_valid,
    output out_sum, out_cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single 1-bit full-adder cell shared
// across all bit positions.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer that adds two WIDTH-bit words
// one bit per clock, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic             last;
  logic             accept;
  logic             rdy;
  logic             vld;
  logic             bsy;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (s),
    .cout (co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = rdy && bus.in_valid;
  // New bit enters at the MSB; works for WIDTH=1.
  assign sum_nx = (sum_sh >> 1)
                | (WIDTH'(s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    vld      = 1'b0;
    bsy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        bsy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        bsy = 1'b1;
        vld = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= bus.in_a;
      b_sh  <= bus.in_b;
      carry <= bus.in_cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nx;
      carry  <= co;
      cnt    <= cnt + 1'b1;
      // Result registers hold until the next completion.
      if (last) begin
        sum_q  <= sum_nx;
        cout_q <= co;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.busy      = bsy;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that time-multiplexes a single 1-bit full-adder cell to add two WIDTH-bit operands.
- Accepts an operand pair over a valid/ready handshake.
- Runs one bit per clock, LSB first, with a registered carry.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between a vector source (register file or stimulus FSM) and a result consumer; it is the sequencer for the full-adder datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair present.
in_ready  output  1  controller can accept operands (high only in IDLE).
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in.
out_valid  output  1  result present (high only in DONE).
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  sum (a + b + cin) mod 2^WIDTH.
out_cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, async):
  - State goes to IDLE.
  - Operand shifters, sum shifter, carry and counter clear to 0.
  - out_sum=0, out_cout=0, out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, RUN, DONE. Binary encoding. in_ready, out_valid and busy decode from state only (no combinational path from inputs).
- IDLE:
  - On an edge with in_valid && in_ready: load a_sh=in_a, b_sh=in_b, carry=in_cin, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Compute s,co = FA(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1.
  - Shift s into sum_sh at the MSB (right shift).
  - carry <= co; cnt <= cnt+1.
  - When cnt==WIDTH-1, the same edge transitions to DONE.
  - Exactly WIDTH RUN edges per operation.
- DONE:
  - out_sum = sum_sh and out_cout = carry, both registered and held stable while out_valid=1.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready low holds DONE indefinitely (backpressure).
- Latency: out_valid rises WIDTH cycles after the input-accept edge.
  - Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH run, release).
  - No overlap of operations.
- Input capture: in_valid, in_a, in_b and in_cin are ignored outside IDLE. Operands need not stay stable after the accept edge.
- Result hold: out_sum/out_cout keep the last result after returning to IDLE, until the next DONE or a reset.
- Counter width: $clog2(WIDTH+1) bits, sized so there is no wrap for WIDTH up to 64.
- WIDTH=1: a single RUN edge, then DONE. The cnt==WIDTH-1 compare is true on the first RUN edge.
- Carry isolation: carry is reloaded from in_cin at every accept, so no carry leaks between operations.
- Reset mid-RUN or mid-DONE: aborts immediately. No out_valid pulse for the aborted operation; all reset values apply.
- Simultaneous events: out_ready high on the DONE entry edge has no effect; out_valid must be seen high for at least 1 cycle.

Decomposition:
- Package serial_add_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a CNT_W helper function.
- One sub-module, fa_bit: a pure combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once as the shared datapath cell.
- Everything else (FSM, shifters, carry register) lives in serial_add_ctrl.

Test Plan:
1. Reset, WIDTH=8: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_sum=8'h00, out_cout=0.
2. Basic add: a=8'h35, b=8'h4A, cin=0, out_ready=1 -> out_valid rises exactly 8 cycles after accept, out_sum=8'h7F, out_cout=0; back to IDLE the next cycle.
3. Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum 8'h00, cout 1. Then a=8'hFF, b=8'hFF, cin=1 -> sum 8'hFF, cout 1, which also checks that the carry does not leak from the prior op.
4. Backpressure: a=8'h12, b=8'h34, out_ready=0 for 5 cycles after DONE -> out_valid held, out_sum=8'h46 stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> IDLE on the next edge.
5. Reset mid-RUN: accept a=8'hAA, b=8'h55, cin=1, then assert rst_n=0 at RUN cycle 3 -> immediate reset values, no out_valid. Then a=8'h01, b=8'h01, cin=0 -> sum 8'h02, cout 0.
6. WIDTH=1 instance: all 8 (a, b, cin) combinations -> {cout, sum} matches the full-adder truth table, with out_valid 1 cycle after accept.
